// File: rtl/conv_frame_sequencer_pkg.sv
// Shared definitions for the convolution frame sequencer: FSM state
// encoding, default geometry and the frame-configuration limit check.
package conv_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_DATA_WIDTH         = 8;
    localparam int unsigned DEF_BUFFER_LENGTH      = 2000;
    localparam int unsigned DEF_KERNEL_ROW_SIZE    = 3;
    localparam int unsigned DEF_KERNEL_COLUMN_SIZE = 3;
    localparam int unsigned DEF_ADDR_WIDTH         = 22;
    localparam int unsigned DEF_DRAIN_CYCLES       = 3;

    // A frame must hold at least one full kernel window and must fit in the
    // line buffer horizontally; there is no upper bound on row count.
    function automatic logic cfg_in_limits(
        input int unsigned col_size,
        input int unsigned row_size,
        input int unsigned buffer_length,
        input int unsigned kernel_rows,
        input int unsigned kernel_cols
    );
        return (col_size >= kernel_cols) &&
               (col_size <= buffer_length) &&
               (row_size >= kernel_rows);
    endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Frame-memory read address generator: walks the pixel index in row-major
// order from the latched base address, gated by stall and the FSM run
// enable, and flags the final read of the frame.
module conv_seq_addr_gen
    import conv_frame_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DIM_WIDTH  = 11,
    parameter int unsigned CNT_WIDTH  = 2 * DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  run,
    input  logic                  stall,
    input  logic [DIM_WIDTH-1:0]  cfg_col_size,
    input  logic [DIM_WIDTH-1:0]  cfg_row_size,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  last
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]  total;
    logic [CNT_WIDTH-1:0]  frame_pixels;
    logic [ADDR_WIDTH-1:0] base;
    logic                  remaining;

    // Both factors widened first so the pixel count never wraps.
    assign frame_pixels = CNT_WIDTH'(cfg_col_size) * CNT_WIDTH'(cfg_row_size);

    // Latch frame geometry on an accepted start, then advance per issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            total <= '0;
            base  <= '0;
        end else if (load) begin
            idx   <= '0;
            total <= frame_pixels;
            base  <= cfg_base_addr;
        end else if (rd_en) begin
            idx   <= idx + CNT_ONE;
        end
    end

    // Read strobe, address and last-pixel flag for the current cycle.
    always_comb begin
        remaining = (idx < total);
        rd_en     = run && !stall && remaining;
        rd_addr   = rd_en ? (base + ADDR_WIDTH'(idx)) : '0;
        last      = rd_en && (idx == (total - CNT_ONE));
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Convolution frame sequencer: validates and latches a frame configuration,
// streams the frame from memory into the line buffer, drains the window
// pipeline and reports completion, abort and window counts.
module conv_frame_sequencer
    import conv_frame_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int unsigned BUFFER_LENGTH      = DEF_BUFFER_LENGTH,
    parameter int unsigned KERNEL_ROW_SIZE    = DEF_KERNEL_ROW_SIZE,
    parameter int unsigned KERNEL_COLUMN_SIZE = DEF_KERNEL_COLUMN_SIZE,
    parameter int unsigned ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int unsigned DRAIN_CYCLES       = DEF_DRAIN_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [$clog2(BUFFER_LENGTH)-1:0]   cfg_col_size,
    input  logic [$clog2(BUFFER_LENGTH)-1:0]   cfg_row_size,
    input  logic [ADDR_WIDTH-1:0]              cfg_base_addr,
    input  logic                               stall,
    output logic                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]              mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]              mem_rd_data,
    output logic [DATA_WIDTH-1:0]              buf_point,
    output logic                               buf_valid_in,
    output logic [$clog2(BUFFER_LENGTH)-1:0]   buf_col_size,
    output logic [$clog2(BUFFER_LENGTH)-1:0]   buf_row_size,
    input  logic                               buf_valid_out,
    output logic                               busy,
    output logic                               done,
    output logic                               err_cfg,
    output logic [2*$clog2(BUFFER_LENGTH)-1:0] win_count
);

    localparam int unsigned CW         = $clog2(BUFFER_LENGTH);
    localparam int unsigned WW         = 2 * CW;
    localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0;
    localparam int unsigned DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               cfg_ok;
    logic               accept;
    logic               run;
    logic               last_rd;

    assign cfg_ok = cfg_in_limits(32'(cfg_col_size), 32'(cfg_row_size),
                                  BUFFER_LENGTH, KERNEL_ROW_SIZE, KERNEL_COLUMN_SIZE);
    assign accept = (state == ST_IDLE) && start && !abort && cfg_ok;
    // Abort kills the read strobe combinationally, in the same cycle.
    assign run    = (state == ST_STREAM) && !abort;

    conv_seq_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (CW),
        .CNT_WIDTH  (WW)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (accept),
        .run           (run),
        .stall         (stall),
        .cfg_col_size  (cfg_col_size),
        .cfg_row_size  (cfg_row_size),
        .cfg_base_addr (cfg_base_addr),
        .rd_en         (mem_rd_en),
        .rd_addr       (mem_rd_addr),
        .last          (last_rd)
    );

    // Frame control FSM with registered busy/done/err_cfg and latched geometry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_cfg      <= 1'b0;
            buf_col_size <= '0;
            buf_row_size <= '0;
            drain_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                state        <= ST_STREAM;
                                busy         <= 1'b1;
                                buf_col_size <= cfg_col_size;
                                buf_row_size <= cfg_row_size;
                            end else begin
                                err_cfg <= 1'b1;
                            end
                        end
                    end
                    ST_STREAM: begin
                        if (last_rd) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        // First DRAIN cycle carries the final buf_valid_in.
                        if (drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One-cycle read latency: pixel valid follows the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_in <= 1'b0;
        end else begin
            buf_valid_in <= mem_rd_en;
        end
    end

    assign buf_point = buf_valid_in ? mem_rd_data : '0;

    // Saturating count of windows seen from accepted start through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
        end else if (accept) begin
            win_count <= '0;
        end else if (buf_valid_out && (state != ST_IDLE) && (win_count != '1)) begin
            win_count <= win_count + WW'(1);
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [10:0] cfg_col_size;
    logic [10:0] cfg_row_size;
    logic [21:0] cfg_base_addr;
    logic        stall;
    logic        mem_rd_en;
    logic [21:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  buf_point;
    logic        buf_valid_in;
    logic [10:0] buf_col_size;
    logic [10:0] buf_row_size;
    logic        buf_valid_out;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic [21:0] win_count;

    int total;
    int bad;

    conv_frame_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_col_size  (cfg_col_size),
        .cfg_row_size  (cfg_row_size),
        .cfg_base_addr (cfg_base_addr),
        .stall         (stall),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .buf_point     (buf_point),
        .buf_valid_in  (buf_valid_in),
        .buf_col_size  (buf_col_size),
        .buf_row_size  (buf_row_size),
        .buf_valid_out (buf_valid_out),
        .busy          (busy),
        .done          (done),
        .err_cfg       (err_cfg),
        .win_count     (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memory: pixel value is a fixed scramble of the address, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0] ^ 8'h5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_rd_addr"}, mem_rd_addr, 0);
        chk({tag, "_bvi"}, buf_valid_in, 0);
        chk({tag, "_point"}, buf_point, 0);
        chk({tag, "_col"}, buf_col_size, 0);
        chk({tag, "_row"}, buf_row_size, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_cfg, 0);
        chk({tag, "_win"}, win_count, 0);
    endtask

    typedef struct {
        int col;
        int row;
        bit exp_err;
    } cfg_vec_t;

    // Runs one frame from start, checking the read stream cycle by cycle.
    task automatic run_frame(input int cols, input int rows, input logic [21:0] base,
                             input int stall_at, input int stall_len, input int abort_at,
                             input bit hold, input bit toggle);
        int nreads = 0, nvalid = 0, done_cyc = -1, last_bvi = -1;
        int stall_cnt = 0, exp_win = 0, abort_cyc = -1, ndone = 0;
        bit prev_rd = 0, fin = 0;
        logic [21:0] prev_addr = '0;
        logic [21:0] exp_addr;
        @(posedge clk); #1;
        cfg_col_size = 11'(cols); cfg_row_size = 11'(rows); cfg_base_addr = base;
        start = 1; stall = 0; abort = 0; buf_valid_out = 0;
        @(negedge clk);
        chk("pre_start_busy", busy, 0);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(posedge clk); #1;
            start = hold;
            if (toggle) cfg_col_size = (cyc % 2 == 1) ? 11'd7 : 11'(cols);
            abort = (abort_at >= 0) && (abort_cyc < 0) && (nreads == abort_at);
            if (abort) abort_cyc = cyc;
            stall = (stall_at >= 0) && (nreads >= stall_at) && (stall_cnt < stall_len);
            if (stall) stall_cnt++;
            buf_valid_out = ((abort_cyc < 0) || (cyc == abort_cyc)) && (cyc % 3 == 0);
            if (buf_valid_out) exp_win++;
            @(negedge clk);
            if (stall) chk("stall_gate", mem_rd_en, 0);
            if (abort) chk("abort_rd", mem_rd_en, 0);
            chk("bvi_latency", buf_valid_in, prev_rd);
            if (prev_rd) chk("buf_point", buf_point, prev_addr[7:0] ^ 8'h5A);
            if (toggle) chk("col_latched", buf_col_size, cols);
            if (abort_cyc < 0 || cyc == abort_cyc) chk("busy", busy, !done);
            else begin
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
            end
            prev_rd = mem_rd_en;
            if (mem_rd_en) begin
                exp_addr = base + 22'(nreads);
                chk("rd_addr", mem_rd_addr, exp_addr);
                prev_addr = exp_addr;
                nreads++;
            end
            if (buf_valid_in) begin nvalid++; last_bvi = cyc; end
            if (done) begin ndone++; done_cyc = cyc; fin = 1; end
            if (abort_cyc >= 0 && cyc >= abort_cyc + 6) fin = 1;
        end
        abort = 0; stall = 0;
        chk("frame_bounded", fin, 1);
        if (abort_at < 0) begin
            chk("n_reads", nreads, cols * rows);
            chk("n_valid", nvalid, cols * rows);
            chk("done_cycle", done_cyc, cols * rows + stall_len + 3);
            chk("drain_gap", done_cyc - last_bvi, 3);
            @(posedge clk); #1;
            start = 0; cfg_col_size = 11'(cols); buf_valid_out = 1;
            @(negedge clk);
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_err", err_cfg, 0);
            chk("win_count", win_count, exp_win);
            @(posedge clk); #1;
            buf_valid_out = 0;
            @(negedge clk);
            chk("no_restart", busy, 0);
            chk("no_restart_rd", mem_rd_en, 0);
            chk("win_hold", win_count, exp_win);
        end else begin
            chk("abort_reads", nreads, abort_at);
            chk("abort_no_done", ndone, 0);
            chk("abort_win", win_count, exp_win);
        end
    endtask

    cfg_vec_t vecs[9];

    initial begin
        total = 0; bad = 0;
        rst_n = 0; start = 0; abort = 0; stall = 0; buf_valid_out = 0;
        cfg_col_size = '0; cfg_row_size = '0; cfg_base_addr = '0;
        vecs[0] = '{2, 4, 1};
        vecs[1] = '{2001, 4, 1};
        vecs[2] = '{5, 1, 1};
        vecs[3] = '{3, 3, 0};
        vecs[4] = '{2000, 3, 0};
        vecs[5] = '{2000, 2, 1};
        vecs[6] = '{0, 0, 1};
        vecs[7] = '{2047, 2047, 1};
        vecs[8] = '{3, 2047, 0};

        #2;
        chk_all_zero("reset");
        #10 rst_n = 1;

        // Config acceptance table; accepted frames are aborted right away.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            cfg_col_size = 11'(vecs[i].col); cfg_row_size = 11'(vecs[i].row);
            cfg_base_addr = 22'h40; start = 1;
            @(negedge clk);
            chk("cfg_idle_rd", mem_rd_en, 0);
            @(posedge clk); #1;
            start = 0;
            @(negedge clk);
            chk($sformatf("cfg%0d_err", i), err_cfg, vecs[i].exp_err);
            chk($sformatf("cfg%0d_busy", i), busy, !vecs[i].exp_err);
            chk($sformatf("cfg%0d_rd", i), mem_rd_en, !vecs[i].exp_err);
            @(posedge clk); #1;
            abort = 1;
            @(negedge clk);
            chk($sformatf("cfg%0d_err_pulse", i), err_cfg, 0);
            @(posedge clk); #1;
            abort = 0;
            @(negedge clk);
            chk($sformatf("cfg%0d_idle", i), busy, 0);
        end

        // start and abort together in IDLE: abort wins.
        @(posedge clk); #1;
        cfg_col_size = 11'd5; cfg_row_size = 11'd4; start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_rd", mem_rd_en, 0);

        run_frame(5, 4, 22'h100, -1, 0, -1, 0, 0);
        run_frame(5, 4, 22'h100, 7, 4, -1, 0, 0);
        run_frame(5, 4, 22'h100, -1, 0, 7, 0, 0);
        run_frame(5, 4, 22'h200, -1, 0, -1, 0, 0);
        run_frame(5, 4, 22'h100, -1, 0, -1, 1, 1);
        run_frame(3, 3, 22'h3FFFF0, -1, 0, -1, 0, 0);

        // Asynchronous reset in the middle of a stream.
        @(posedge clk); #1;
        cfg_col_size = 11'd5; cfg_row_size = 11'd4; cfg_base_addr = 22'h300;
        start = 1; buf_valid_out = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk_all_zero("midrst");
        buf_valid_out = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_rd", mem_rd_en, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
